// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the conv layer 2 frame sequencer.
// Pure declarations; no latency or backpressure of its own.
package conv_pkg;
    localparam int C2_WIDTH  = 13;
    localparam int C2_HEIGHT = 13;
    localparam int C2_K      = 3;
    localparam int C2_IN_CH  = 8;
    localparam int C2_OUT_CH = 16;
    localparam int C2_NPIX   = C2_WIDTH * C2_HEIGHT;
    localparam int C2_NOUT   = (C2_WIDTH - C2_K + 1) * (C2_HEIGHT - C2_K + 1);

    typedef enum logic [2:0] {
        C2_IDLE,
        C2_STREAM,
        C2_FLUSH,
        C2_DRAIN,
        C2_DONE
    } c2_state_e;
endpackage

// File: rtl/conv2_res_collector.sv
// Captures conv layer 2 results into the result-memory write port, capped at NOUT per frame.
// Latency: one cycle from conv_valid to res_wr_en; no backpressure, results past the cap are dropped.
module conv2_res_collector
    import conv_pkg::*;
#(
    parameter int OUT_CH = C2_OUT_CH,
    parameter int RES_AW = 7,
    parameter int NOUT   = C2_NOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              conv_valid,
    input  logic [OUT_CH-1:0] conv_out,
    output logic              res_wr_en,
    output logic [RES_AW-1:0] res_wr_addr,
    output logic [OUT_CH-1:0] res_wr_data,
    output logic              full
);
    logic [RES_AW-1:0] cnt_q, cnt_d;
    logic [RES_AW-1:0] addr_q, addr_d;
    logic [OUT_CH-1:0] data_q, data_d;
    logic              wr_en_q, wr_en_d;
    logic              take;

    // Counter stops at NOUT, so it can never wrap back onto written slots.
    assign full = (cnt_q == RES_AW'(NOUT));
    assign take = en && conv_valid && !full;

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (take) begin
            wr_en_d = 1'b1;
            addr_d  = cnt_q;
            data_d  = conv_out;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign res_wr_en   = wr_en_q;
    assign res_wr_addr = addr_q;
    assign res_wr_data = data_q;
endmodule

// File: rtl/conv2_frame_seq.sv
// Streams one WIDTHxHEIGHT map to conv layer 2 gap-free and collects its results; CONV2_SEQ_WATCHDOG_EN adds a DRAIN watchdog.
// Latency: pixel n on pixel_out 2 cycles after address n; backpressure: none, start ignored while busy.
module conv2_frame_seq
    import conv_pkg::*;
#(
    parameter int WIDTH     = C2_WIDTH,
    parameter int HEIGHT    = C2_HEIGHT,
    parameter int K         = C2_K,
    parameter int IN_CH     = C2_IN_CH,
    parameter int OUT_CH    = C2_OUT_CH,
    parameter int FM_AW     = 8,
    parameter int RES_AW    = 7,
    parameter int DRAIN_MAX = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fm_rd_en,
    output logic [FM_AW-1:0]  fm_rd_addr,
    input  logic [IN_CH-1:0]  fm_rd_data,
    output logic              conv_rst_n,
    output logic [IN_CH-1:0]  pixel_out,
    input  logic [OUT_CH-1:0] conv_out,
    input  logic              conv_valid,
    output logic              res_wr_en,
    output logic [RES_AW-1:0] res_wr_addr,
    output logic [OUT_CH-1:0] res_wr_data,
    output logic              err
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int NOUT = (WIDTH - K + 1) * (HEIGHT - K + 1);
    localparam logic [FM_AW-1:0] LAST_PIX = FM_AW'(NPIX - 1);

    c2_state_e         state_q, state_d;
    logic [FM_AW-1:0]  pix_q, pix_d;
    logic              flush_q, flush_d;
    logic              rd_vld_q;
    logic [IN_CH-1:0]  pixel_q, pixel_d;
    logic              conv_rst_n_q, conv_rst_n_d;
    logic              accept, active, res_full;
`ifdef CONV2_SEQ_WATCHDOG_EN
    localparam int DW = $clog2(DRAIN_MAX + 1);
    logic [DW-1:0]     drain_q, drain_d;
    logic              err_q, err_d;
`endif

    assign accept = (state_q == C2_IDLE) && start;
    assign active = (state_q == C2_STREAM) || (state_q == C2_FLUSH) || (state_q == C2_DRAIN);

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        flush_d = flush_q;
`ifdef CONV2_SEQ_WATCHDOG_EN
        err_d   = err_q;
        drain_d = (state_q == C2_DRAIN) ? drain_q + 1'b1 : '0;
`endif
        case (state_q)
            C2_IDLE: begin
                if (start) begin
                    state_d = C2_STREAM;
                    pix_d   = '0;
`ifdef CONV2_SEQ_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                end
            end
            C2_STREAM: begin
                if (pix_q == LAST_PIX) begin
                    state_d = C2_FLUSH;
                    flush_d = 1'b0;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            // Two cycles covers the memory read plus the pixel register.
            C2_FLUSH: begin
                if (flush_q) state_d = C2_DRAIN;
                else         flush_d = 1'b1;
            end
            C2_DRAIN: begin
                if (res_full) begin
                    state_d = C2_DONE;
`ifdef CONV2_SEQ_WATCHDOG_EN
                end else if (drain_q == DW'(DRAIN_MAX - 1)) begin
                    state_d = C2_DONE;
                    err_d   = 1'b1;
`endif
                end
            end
            C2_DONE: state_d = C2_IDLE;
            default: state_d = C2_IDLE;
        endcase

        // Layer leaves reset together with pixel 0 and re-enters it on DONE.
        conv_rst_n_d = ((state_d == C2_STREAM) || (state_d == C2_FLUSH) || (state_d == C2_DRAIN))
                       && (conv_rst_n_q || rd_vld_q);
        pixel_d      = rd_vld_q ? fm_rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= C2_IDLE;
            pix_q        <= '0;
            flush_q      <= 1'b0;
            rd_vld_q     <= 1'b0;
            pixel_q      <= '0;
            conv_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            flush_q      <= flush_d;
            rd_vld_q     <= fm_rd_en;
            pixel_q      <= pixel_d;
            conv_rst_n_q <= conv_rst_n_d;
        end
    end

`ifdef CONV2_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    conv2_res_collector #(
        .OUT_CH (OUT_CH),
        .RES_AW (RES_AW),
        .NOUT   (NOUT)
    ) u_collect (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (accept),
        .en          (active),
        .conv_valid  (conv_valid),
        .conv_out    (conv_out),
        .res_wr_en   (res_wr_en),
        .res_wr_addr (res_wr_addr),
        .res_wr_data (res_wr_data),
        .full        (res_full)
    );

    assign busy       = (state_q != C2_IDLE);
    assign done       = (state_q == C2_DONE);
    assign fm_rd_en   = (state_q == C2_STREAM);
    assign fm_rd_addr = pix_q;
    assign conv_rst_n = conv_rst_n_q;
    assign pixel_out  = pixel_q;
endmodule

// File: tb/tb_conv2_frame_seq.sv
// Directed bench for conv2_frame_seq: memory model, conv-valid stimulus, result scoreboard.
// Cycle k means the sample taken 1 time unit after the k-th rising edge following the accepted start.
module tb_conv2_frame_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, fm_rd_en, conv_rst_n, res_wr_en, err;
    logic [7:0]  fm_rd_addr;
    logic [7:0]  fm_rd_data = '0;
    logic [7:0]  pixel_out;
    logic [15:0] conv_out = '0;
    logic        conv_valid = 1'b0;
    logic [6:0]  res_wr_addr;
    logic [15:0] res_wr_data;

    logic [7:0]  mem [0:168];
    logic [22:0] sb [$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];

    conv2_frame_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .fm_rd_en    (fm_rd_en),
        .fm_rd_addr  (fm_rd_addr),
        .fm_rd_data  (fm_rd_data),
        .conv_rst_n  (conv_rst_n),
        .pixel_out   (pixel_out),
        .conv_out    (conv_out),
        .conv_valid  (conv_valid),
        .res_wr_en   (res_wr_en),
        .res_wr_addr (res_wr_addr),
        .res_wr_data (res_wr_data),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_rd_en"}, fm_rd_en, 0);
        chk({pfx, "_rd_addr"}, fm_rd_addr, 0);
        chk({pfx, "_conv_rst_n"}, conv_rst_n, 0);
        chk({pfx, "_pixel"}, pixel_out, 0);
        chk({pfx, "_wr_en"}, res_wr_en, 0);
        chk({pfx, "_wr_addr"}, res_wr_addr, 0);
        chk({pfx, "_wr_data"}, res_wr_data, 0);
        chk({pfx, "_err"}, err, 0);
    endtask

    // Valids start at cycle 40, one per cycle; only the first 121 may produce writes.
    task automatic frame(input int nvalid, input int poke_stream, input bit poke_done,
                         input int abort_at, input int exp_done, input bit exp_err);
        int k, sent, writes;
        bit finished;
        logic [22:0] e;
        for (int i = 0; i < 169; i++) mem[i] = 8'($urandom);
        sb.delete();
        sent = 0; writes = 0; finished = 0;
        start = 1'b1; tick(); start = 1'b0; k = 1;
        chk("busy_on_start", busy, 1);
        chk("err_clr_on_start", err, 0);
        while (!finished && k < 400) begin
            if (k <= 169) begin
                chk("rd_en", fm_rd_en, 1);
                chk("rd_addr", fm_rd_addr, k - 1);
            end else begin
                chk("rd_en_off", fm_rd_en, 0);
            end
            if (k >= 3 && k <= 171) begin
                chk("pixel", pixel_out, mem[k-3]);
                chk("conv_rst_n_on", conv_rst_n, 1);
            end else if (k <= 2) begin
                chk("conv_rst_n_pre", conv_rst_n, 0);
            end else if (!done) begin
                chk("pixel_drain", pixel_out, 0);
                chk("conv_rst_n_drain", conv_rst_n, 1);
            end
            if (res_wr_en) begin
                writes++;
                chk("write_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", res_wr_addr, e[22:16]);
                    chk("wr_data", res_wr_data, e[15:0]);
                end
            end
            if (k == abort_at) begin
                rst_n = 1'b0; conv_valid = 1'b0;
                #1;
                check_zero("abort");
                @(negedge clk);
                rst_n = 1'b1;
                finished = 1;
            end else if (done) begin
                chk("done_cycle", k, exp_done);
                chk("busy_in_done", busy, 1);
                chk("conv_rst_n_done", conv_rst_n, 0);
                chk("err_at_done", err, exp_err);
                chk("write_count", writes, (nvalid < 121) ? nvalid : 121);
                chk("sb_empty", sb.size(), 0);
                conv_valid = 1'b0;
                start = poke_done;
                tick();
                start = 1'b0;
                chk("done_single", done, 0);
                chk("busy_off", busy, 0);
                chk("start_in_done_ignored", fm_rd_en, 0);
                chk("err_sticky", err, exp_err);
                finished = 1;
            end else begin
                conv_valid = (k >= 40) && (sent < nvalid);
                if (conv_valid) begin
                    conv_out = 16'(sent + 1);
                    if (sent < 121) sb.push_back({7'(sent), 16'(sent + 1)});
                    sent++;
                end
                start = (k == poke_stream);
                tick();
                k++;
            end
        end
        if (!finished) chk("frame_timeout", k, exp_done);
        start = 1'b0;
        conv_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_zero("idle");

        // Start re-pulsed mid-stream and in DONE: both ignored.
        frame(121, 50, 1'b1, 0, 173, 1'b0);
        // Accepted the cycle after DONE; 4 extra valids must be dropped.
        frame(125, 0, 1'b0, 0, 173, 1'b0);
        // Reset while pixel 80 is on pixel_out, then a clean frame.
        frame(121, 0, 1'b0, 83, 173, 1'b0);
        frame(121, 0, 1'b0, 0, 173, 1'b0);
`ifdef CONV2_SEQ_WATCHDOG_EN
        frame(100, 0, 1'b0, 0, 172 + 64, 1'b1);
        frame(121, 0, 1'b0, 0, 173, 1'b0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
